// File: rtl/sram_bus_pkg.sv
// Shared types and address map for the SRAM bus arbiter.
package sram_bus_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;

    typedef enum logic {GNT_IF, GNT_MEM} grant_e;

    localparam logic [31:0] BASE_LO = 32'h8000_0000;
    localparam logic [31:0] BASE_HI = 32'h803F_FFFF;
    localparam logic [31:0] EXT_LO  = 32'h8040_0000;
    localparam logic [31:0] EXT_HI  = 32'h807F_FFFF;

endpackage

// File: rtl/sram_addr_decode.sv
// Maps a CPU byte address onto BaseRAM / ExtRAM and the SRAM word address.
module sram_addr_decode
    import sram_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = 20
) (
    input  logic [31:0]       addr,
    output logic              is_base,
    output logic              is_ext,
    output logic [ADDR_W-1:0] word_addr
);

    assign is_base   = (addr >= BASE_LO) && (addr <= BASE_HI);
    assign is_ext    = (addr >= EXT_LO) && (addr <= EXT_HI);
    assign word_addr = addr[ADDR_W+1:2];

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares BaseRAM/ExtRAM between fetch and data ports with timed setup/strobe/hold phases.
module sram_bus_arbiter
    import sram_bus_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              mem_req,
    input  logic [3:0]        mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_ack,
    output logic [31:0]       mem_rdata,
    output logic              mem_err,
    output logic              base_ce_n,
    output logic              base_oe_n,
    output logic              base_we_n,
    output logic [3:0]        base_be_n,
    output logic [ADDR_W-1:0] base_addr,
    output logic [31:0]       base_wdata,
    input  logic [31:0]       base_rdata,
    output logic              ext_ce_n,
    output logic              ext_oe_n,
    output logic              ext_we_n,
    output logic [3:0]        ext_be_n,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [31:0]       ext_wdata,
    input  logic [31:0]       ext_rdata,
    output logic              busy
);

    state_e            state_q, state_d;
    grant_e            gnt_q, gnt_d;
    logic              sel_base_q, sel_ext_q, write_q, err_q;
    logic [ADDR_W-1:0] word_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic [3:0]        cnt_q;
    logic [31:0]       if_rdata_q, mem_rdata_q;

    logic [31:0]       req_addr;
    logic              req_base, req_ext, req_mapped, req_any, req_write;
    logic [ADDR_W-1:0] req_word;
    logic              active, capture;
    logic [31:0]       sel_rdata;

    // Fixed priority: the data port always wins a tie.
    assign gnt_d      = mem_req ? GNT_MEM : GNT_IF;
    assign req_addr   = mem_req ? mem_addr : if_addr;
    assign req_any    = mem_req | if_req;
    assign req_write  = mem_req && (mem_we != 4'h0);
    assign req_mapped = req_base | req_ext;

    sram_addr_decode #(
        .ADDR_W(ADDR_W)
    ) u_decode (
        .addr     (req_addr),
        .is_base  (req_base),
        .is_ext   (req_ext),
        .word_addr(req_word)
    );

    assign capture   = (state_q == ACCESS) && (cnt_q == 4'd0) && !write_q;
    assign sel_rdata = sel_base_q ? base_rdata : ext_rdata;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_any) state_d = req_mapped ? SETUP : DONE;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (cnt_q == 4'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_IF;
            sel_base_q  <= 1'b0;
            sel_ext_q   <= 1'b0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            be_q        <= 4'h0;
            cnt_q       <= 4'd0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_any) begin
                gnt_q      <= gnt_d;
                sel_base_q <= req_base;
                sel_ext_q  <= req_ext;
                word_q     <= req_word;
                wdata_q    <= mem_wdata;
                be_q       <= req_write ? ~mem_we : 4'h0;
                write_q    <= req_write;
                err_q      <= !req_mapped;
                // Unmapped requests skip the SRAM and complete with zero data.
                if (!req_mapped) begin
                    if (gnt_d == GNT_MEM) mem_rdata_q <= '0;
                    else                  if_rdata_q  <= '0;
                end
            end
            if (state_q == SETUP) begin
                cnt_q <= 4'(WAIT_CYCLES - 1);
            end else if (state_q == ACCESS && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (capture) begin
                if (gnt_q == GNT_MEM) mem_rdata_q <= sel_rdata;
                else                  if_rdata_q  <= sel_rdata;
            end
        end
    end

    // Controls derive only from registered state, so reset releases the bus at once.
    assign active = (state_q == SETUP) || (state_q == ACCESS);

    assign base_ce_n  = !(sel_base_q && active);
    assign base_oe_n  = !(sel_base_q && active && !write_q);
    assign base_we_n  = !(sel_base_q && (state_q == ACCESS) && write_q);
    assign base_be_n  = (sel_base_q && state_q != IDLE) ? be_q : 4'hF;
    assign base_addr  = sel_base_q ? word_q : '0;
    assign base_wdata = (sel_base_q && write_q) ? wdata_q : '0;

    assign ext_ce_n   = !(sel_ext_q && active);
    assign ext_oe_n   = !(sel_ext_q && active && !write_q);
    assign ext_we_n   = !(sel_ext_q && (state_q == ACCESS) && write_q);
    assign ext_be_n   = (sel_ext_q && state_q != IDLE) ? be_q : 4'hF;
    assign ext_addr   = sel_ext_q ? word_q : '0;
    assign ext_wdata  = (sel_ext_q && write_q) ? wdata_q : '0;

    assign if_ack    = (state_q == DONE) && (gnt_q == GNT_IF);
    assign mem_ack   = (state_q == DONE) && (gnt_q == GNT_MEM);
    assign mem_err   = mem_ack && err_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed plus randomized checks of the SRAM arbiter against a transaction-level model.
module tb_sram_bus_arbiter;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0, mem_req = 1'b0;
    logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
    logic [3:0]  mem_we = '0;
    logic        if_ack, mem_ack, mem_err, busy;
    logic [31:0] if_rdata, mem_rdata;
    logic        base_ce_n, base_oe_n, base_we_n, ext_ce_n, ext_oe_n, ext_we_n;
    logic [3:0]  base_be_n, ext_be_n;
    logic [19:0] base_addr, ext_addr;
    logic [31:0] base_wdata, ext_wdata;
    logic [31:0] base_rdata = '0, ext_rdata = '0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_if_rdata = '0, exp_mem_rdata = '0;
    bit          mem_known = 1'b1;

    sram_bus_arbiter #(
        .WAIT_CYCLES(W),
        .ADDR_W     (20)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err),
        .base_ce_n (base_ce_n),
        .base_oe_n (base_oe_n),
        .base_we_n (base_we_n),
        .base_be_n (base_be_n),
        .base_addr (base_addr),
        .base_wdata(base_wdata),
        .base_rdata(base_rdata),
        .ext_ce_n  (ext_ce_n),
        .ext_oe_n  (ext_oe_n),
        .ext_we_n  (ext_we_n),
        .ext_be_n  (ext_be_n),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_rdata (ext_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request on one port; cycle 0 is the IDLE cycle in which the request is first seen.
    task automatic run_txn(input bit is_mem, input logic [31:0] addr, input logic [3:0] we,
                           input logic [31:0] wd);
        bit          in_base, in_ext, mapped, wr;
        logic [19:0] word;
        logic [31:0] bd, ed, got_rd;
        logic        got_err;
        int          lat, sel_ce, oth_ce, we_lo, oe_lo, bad;
        in_base = (addr >= 32'h8000_0000) && (addr < 32'h8040_0000);
        in_ext  = (addr >= 32'h8040_0000) && (addr < 32'h8080_0000);
        mapped  = in_base || in_ext;
        wr      = is_mem && (we != 4'h0);
        word    = addr[21:2];
        bd = $urandom;
        ed = $urandom;
        lat = -1; sel_ce = 0; oth_ce = 0; we_lo = 0; oe_lo = 0; bad = 0;
        got_rd = '0; got_err = 1'b0;
        @(posedge clk); #1;
        base_rdata = bd;
        ext_rdata  = ed;
        if (is_mem) begin
            mem_req = 1'b1; mem_addr = addr; mem_we = we; mem_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (busy !== (k > 0)) bad++;
            if (base_ce_n === 1'b0) begin
                if (in_base) sel_ce++; else oth_ce++;
                if (base_addr !== word || base_be_n !== (wr ? ~we : 4'h0)) bad++;
            end
            if (ext_ce_n === 1'b0) begin
                if (in_ext) sel_ce++; else oth_ce++;
                if (ext_addr !== word || ext_be_n !== (wr ? ~we : 4'h0)) bad++;
            end
            if (base_we_n === 1'b0 || ext_we_n === 1'b0) we_lo++;
            if (base_oe_n === 1'b0 || ext_oe_n === 1'b0) oe_lo++;
            if (mem_err === 1'b1 && mem_ack !== 1'b1) bad++;
            if ((is_mem ? if_ack : mem_ack) === 1'b1) bad++;
            if ((is_mem ? mem_ack : if_ack) === 1'b1) begin
                lat     = k;
                got_rd  = is_mem ? mem_rdata : if_rdata;
                got_err = mem_err;
                if (wr && in_base && (base_addr !== word || base_wdata !== wd ||
                                      base_we_n !== 1'b1 || base_ce_n !== 1'b1)) bad++;
                if (wr && in_ext && (ext_addr !== word || ext_wdata !== wd ||
                                     ext_we_n !== 1'b1 || ext_ce_n !== 1'b1)) bad++;
                mem_req = 1'b0;
                if_req  = 1'b0;
                break;
            end
        end
        mem_req = 1'b0;
        if_req  = 1'b0;
        chk("latency", lat, mapped ? W + 2 : 1);
        chk("sel_ce_cycles", sel_ce, mapped ? W + 1 : 0);
        chk("other_ce_cycles", oth_ce, 0);
        chk("we_cycles", we_lo, (wr && mapped) ? W : 0);
        chk("oe_cycles", oe_lo, (!wr && mapped) ? W + 1 : 0);
        chk("pin_protocol", bad, 0);
        if (is_mem) chk("mem_err", 32'(got_err), 32'(!mapped));
        if (!(wr && mapped)) begin
            chk(is_mem ? "mem_rdata" : "if_rdata", got_rd,
                !mapped ? 32'h0 : (in_base ? bd : ed));
            if (is_mem) begin exp_mem_rdata = got_rd; mem_known = 1'b1; end
            else exp_if_rdata = got_rd;
            if (is_mem) exp_mem_rdata = !mapped ? 32'h0 : (in_base ? bd : ed);
            else exp_if_rdata = !mapped ? 32'h0 : (in_base ? bd : ed);
        end else begin
            mem_known = 1'b0;
        end
        if (is_mem) chk("if_rdata_held", if_rdata, exp_if_rdata);
        else if (mem_known) chk("mem_rdata_held", mem_rdata, exp_mem_rdata);
    endtask

    initial begin
        int mack, iack, fsetup, overlap, acks;
        logic [31:0] bd, ed, a;
        logic [31:0] bnd [5];
        bnd[0] = 32'h803F_FFFC; bnd[1] = 32'h8040_0000; bnd[2] = 32'h807F_FFFC;
        bnd[3] = 32'h8080_0000; bnd[4] = 32'h7FFF_FFFC;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl_n", 32'({base_ce_n, base_oe_n, base_we_n, ext_ce_n, ext_oe_n, ext_we_n}),
            32'h3F);
        chk("rst_be_n", 32'({base_be_n, ext_be_n}), 32'hFF);
        chk("rst_addr", 32'({base_addr, ext_addr}), 32'h0);
        chk("rst_wdata", base_wdata | ext_wdata, 32'h0);
        chk("rst_flags", 32'({if_ack, mem_ack, mem_err, busy}), 32'h0);
        chk("rst_rdata", if_rdata | mem_rdata, 32'h0);
        reset = 1'b0;

        // Directed cases from the plan, boundaries included.
        run_txn(1'b1, 32'h8000_0010, 4'h0, 32'h0);
        run_txn(1'b1, 32'h8040_0008, 4'b0011, 32'hAABB_CCDD);
        run_txn(1'b0, 32'h8040_0000, 4'h0, 32'h0);
        run_txn(1'b1, 32'h8080_0000, 4'h0, 32'h0);
        run_txn(1'b0, 32'h803F_FFFC, 4'h0, 32'h0);
        run_txn(1'b1, 32'h807F_FFFC, 4'h0, 32'h0);
        run_txn(1'b0, 32'h9000_0000, 4'h0, 32'h0);

        // Simultaneous requests: data first, fetch follows after one IDLE cycle.
        bd = $urandom;
        ed = $urandom;
        mack = -1; iack = -1; fsetup = -1; overlap = 0;
        @(posedge clk); #1;
        base_rdata = bd; ext_rdata = ed;
        if_req = 1'b1; if_addr = 32'h8000_0000;
        mem_req = 1'b1; mem_addr = 32'h8040_0000; mem_we = 4'h0;
        for (int k = 0; k <= 15; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (mem_ack === 1'b1 && if_ack === 1'b1) overlap++;
            if (mem_ack === 1'b1 && mack < 0) begin mack = k; mem_req = 1'b0; end
            if (base_ce_n === 1'b0 && fsetup < 0) fsetup = k;
            if (if_ack === 1'b1 && iack < 0) begin iack = k; if_req = 1'b0; end
        end
        if_req = 1'b0; mem_req = 1'b0;
        chk("both_mem_ack", mack, W + 2);
        chk("both_if_setup", fsetup, W + 4);
        chk("both_if_ack", iack, 2 * W + 5);
        chk("both_overlap", overlap, 0);
        chk("both_mem_rdata", mem_rdata, ed);
        chk("both_if_rdata", if_rdata, bd);
        exp_mem_rdata = ed; exp_if_rdata = bd; mem_known = 1'b1;

        // Reset in the middle of a write strobe.
        @(posedge clk); #1;
        mem_req = 1'b1; mem_addr = 32'h8000_0020; mem_we = 4'hF; mem_wdata = $urandom;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_we_n", 32'(base_we_n), 32'h0);
        reset = 1'b1;
        #1;
        chk("reset_we_n", 32'(base_we_n), 32'h1);
        chk("reset_ce_n", 32'(base_ce_n), 32'h1);
        chk("reset_busy", 32'(busy), 32'h0);
        mem_req = 1'b0;
        acks = 0;
        repeat (3) begin @(posedge clk); #1; if (mem_ack === 1'b1) acks++; end
        reset = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (mem_ack === 1'b1) acks++; end
        chk("no_ack_after_abort", acks, 0);
        exp_if_rdata = '0; exp_mem_rdata = '0; mem_known = 1'b1;
        run_txn(1'b0, 32'h803F_FFFC, 4'h0, 32'h0);

        // Randomized traffic across both RAMs, the edges and unmapped space.
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000 | ($urandom & 32'h003F_FFFF);
                1:       a = 32'h8040_0000 | ($urandom & 32'h003F_FFFF);
                2:       a = bnd[$urandom_range(0, 4)];
                default: a = $urandom;
            endcase
            run_txn(1'($urandom_range(0, 1)), a,
                    $urandom_range(0, 1) ? 4'($urandom) : 4'h0, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
